set_cmd_sequencer: RTL

- Upstream feeder and downstream collector for the SET candidate-counting engine.
- Assembles byte-serial host commands into the engine's central, radius and mode operands.
- Issues a one-cycle enable pulse when the engine is idle, captures the candidate count on the engine's valid strobe, and buffers the results in a ready/valid result FIFO.
- Command assembly overlaps the engine's busy period so back-to-back commands issue with minimal gaps.

---
 rtl/set_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/set_cmd_sequencer.sv
// set_cmd_sequencer
//
// Purpose
//   Front end and result collector for the SET candidate-counting engine.
//   Host commands arrive as 5 bytes:
//     b0 = {2'b00, mode[1:0], radius[11:8]}
//     b1 = radius[7:0]
//     b2..b4 = central[23:16], central[15:8], central[7:0]
//   A complete command moves into a pending register. The dispatch FSM issues
//   it to the engine with a one-cycle set_en pulse. The FSM then waits for
//   set_valid and pushes set_candidate into a show-ahead result FIFO. The next
//   command is assembled while the current one is in flight.
//
// Handshakes (all valid/ready pairs)
//   A transfer happens at a rising edge where valid && ready are both high.
//   valid must not depend on ready. in_ready and res_valid depend only on
//   registered state.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   host byte handshake, in_data command byte
//   set_en              one-cycle issue pulse to the engine
//   set_central/radius/mode  registered operands, stable from issue to the next issue
//   set_busy            engine busy; no issue while high
//   set_valid           engine result strobe, honoured only in WAIT
//   set_candidate       engine result byte
//   res_valid/res_ready result FIFO handshake, res_data FIFO head
//   res_count           FIFO occupancy
//   err                 sticky watchdog timeout flag
//   dbg_state           dispatch FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//
// Build option
//   SET_TIMEOUT_EN : when defined, adds a WAIT watchdog of TIMEOUT_CYCLES
//   cycles. On expiry the block pushes 8'hFF, sets err and returns to IDLE.
//   When undefined, WAIT has no limit and err is tied 0.

module set_cmd_sequencer #(
  parameter int unsigned RES_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  output logic                         set_en,
  output logic [23:0]                  set_central,
  output logic [11:0]                  set_radius,
  output logic [1:0]                   set_mode,
  input  logic                         set_busy,
  input  logic                         set_valid,
  input  logic [7:0]                   set_candidate,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [7:0]                   res_data,
  output logic [$clog2(RES_DEPTH):0]   res_count,
  output logic                         err,
  output logic [1:0]                   dbg_state
);

  localparam int unsigned AW = $clog2(RES_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Command assembler
  // ---------------------------------------------------------------------------
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;          // {b0, b1, b2, b3} after four bytes
  logic [37:0] pend_q, pend_d;        // {mode, radius, central}
  logic        cmd_pending_q, cmd_pending_d;
  logic        in_accept;
  logic        last_accept;

  state_e      state_q, state_d;

  // The only stall is a fifth byte that has nowhere to go because the pending
  // slot is still occupied.
  assign in_ready    = !(cmd_pending_q && (byte_cnt_q == 3'd4));
  assign in_accept   = in_valid && in_ready;
  assign last_accept = in_accept && (byte_cnt_q == 3'd4);

  always_comb begin
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    pend_d        = pend_q;
    cmd_pending_d = cmd_pending_q;
    if (in_accept) begin
      if (byte_cnt_q == 3'd4) begin
        byte_cnt_d = 3'd0;
        // asm_q[29:28] = mode, [27:16] = radius, [15:0] = central[23:8]
        pend_d        = {asm_q[29:0], in_data};
        cmd_pending_d = 1'b1;
      end else begin
        asm_d      = {asm_q[23:0], in_data};
        byte_cnt_d = byte_cnt_q + 3'd1;
      end
    end
    // An issue consumes the pending slot. A new final byte at the same edge
    // refills the slot, so that case takes priority.
    if ((state_q == ST_ISSUE) && !last_accept) begin
      cmd_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q    <= 3'd0;
      asm_q         <= '0;
      pend_q        <= '0;
      cmd_pending_q <= 1'b0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      pend_q        <= pend_d;
      cmd_pending_q <= cmd_pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count_q, count_d;
  logic          load_ops;
  logic          push;
  logic [7:0]    push_data;
  logic          pop;
  logic [37:0]   ops_q;

`ifdef SET_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    load_ops  = 1'b0;
    push      = 1'b0;
    push_data = set_candidate;
`ifdef SET_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A free FIFO slot at issue time guarantees room for the result.
        if (cmd_pending_q && !set_busy && (count_q < CW'(RES_DEPTH))) begin
          state_d  = ST_ISSUE;
          load_ops = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef SET_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      ST_WAIT: begin
        if (set_valid) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef SET_TIMEOUT_EN
        else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          push      = 1'b1;
          push_data = 8'hFF;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      // Operands load when the FSM enters ISSUE, so they are valid during the
      // set_en cycle.
      if (load_ops) begin
        ops_q <= pend_q;
      end
    end
  end

`ifdef SET_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = |TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  assign set_en      = (state_q == ST_ISSUE);
  assign set_mode    = ops_q[37:36];
  assign set_radius  = ops_q[35:24];
  assign set_central = ops_q[23:0];
  assign dbg_state   = state_q;

  // ---------------------------------------------------------------------------
  // Result FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [RES_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;

  // A pop when empty is dropped. A push into an empty FIFO with a pop at the
  // same edge therefore leaves one entry.
  assign pop = res_ready && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // RES_DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign res_valid = (count_q != '0);
  assign res_data  = mem_q[rd_ptr_q];
  assign res_count = count_q;

endmodule
